led_breath_seq: RTL and testbench

- Sequencer for the LED PWM datapath. Drives a breathing cycle on one LED at a time: ramp up, hold on, ramp down, hold off.
- Steps round-robin across N_LED outputs.
- Runs once through all channels on `start`, or loops until `stop`.
- Sits between the board-level control logic (start/stop buttons or CPU register) and the LED pins.

---
 rtl/led_breath_pkg.sv | 23 ++
 rtl/led_pwm_gen.sv | 37 +++
 rtl/led_breath_seq.sv | 197 +++++++++++++++++++
 tb/tb_led_breath_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_breath_pkg.sv
// led_breath_pkg: shared types and width helpers for the LED breathing sequencer.
package led_breath_pkg;

  // Sequencer phases for one LED channel.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_HOLD_ON   = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_HOLD_OFF  = 3'd4
  } state_t;

  // Bits needed to hold a duty value in 0..pwm_max inclusive.
  function automatic int duty_width(input int pwm_max);
    return $clog2(pwm_max + 1);
  endfunction

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: free-running PWM period counter with a registered compare output.
// The counter runs only while enabled; clr restarts the period from zero and
// forces the output low on the same edge.
module led_pwm_gen
  import led_breath_pkg::*;
#(
  parameter int PWM_MAX = 200,
  parameter int DW      = duty_width(PWM_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [DW-1:0] cmp,
  output logic          period_end,
  output logic          pwm_out
);

  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_MAX - 1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  logic [DW-1:0] pwm_cnt;

  assign period_end = en && (pwm_cnt == CNT_LAST);

  // Period counter and compare register; idle or cleared means counter at zero, output low.
  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < cmp);
      pwm_cnt <= period_end ? '0 : pwm_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_breath_seq.sv
// led_breath_seq: breathing sequencer for the LED PWM datapath.
// Each channel in turn ramps up, holds on, ramps down and holds off, then the
// sequencer moves to the next channel. A single pass ends with a done pulse;
// a looped run keeps cycling until stop.
// Build option: define LED_BREATH_GAMMA_EN to square the duty
// (duty*duty/PWM_MAX, truncating) before the PWM compare; otherwise the
// compare value is the duty itself. State timing is the same in both builds.
//
// state        | meaning
// ST_IDLE      | outputs quiet, waiting for start
// ST_RAMP_UP   | duty climbs one step per tick up to PWM_MAX
// ST_HOLD_ON   | full brightness for HOLD_TICKS ticks
// ST_RAMP_DOWN | duty falls one step per tick down to 0
// ST_HOLD_OFF  | dark for HOLD_TICKS ticks, then next channel or finish
module led_breath_seq
  import led_breath_pkg::*;
#(
  parameter int PWM_MAX    = 200,
  parameter int STEP_DIV   = 1,
  parameter int HOLD_TICKS = 50,
  parameter int N_LED      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  output logic [N_LED-1:0]             led,
  output logic [idx_width(N_LED)-1:0]  cur_ch,
  output logic                         busy,
  output logic                         done
);

  localparam int DW = duty_width(PWM_MAX);
  localparam int CW = idx_width(N_LED);
  localparam int SW = idx_width(STEP_DIV);
  localparam int HW = idx_width(HOLD_TICKS);

  localparam logic [DW-1:0] DUTY_ONE  = DW'(1);
  localparam logic [DW-1:0] DUTY_PEN  = DW'(PWM_MAX - 1);
  localparam logic [SW-1:0] DIV_LAST  = SW'(STEP_DIV - 1);
  localparam logic [SW-1:0] DIV_ONE   = SW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [CW-1:0] CH_LAST   = CW'(N_LED - 1);
  localparam logic [CW-1:0] CH_ONE    = CW'(1);

  state_t        state;
  logic [DW-1:0] duty;
  logic [DW-1:0] cmp;
  logic [SW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt;
  logic          loop_q;
  logic          period_end;
  logic          pwm_out;
  logic          active;
  logic          start_acc;
  logic          stop_acc;
  logic          tick;

  assign active    = (state != ST_IDLE);
  assign start_acc = (state == ST_IDLE) && start && !stop;
  assign stop_acc  = active && stop;
  assign tick      = period_end && (div_cnt == DIV_LAST);

`ifdef LED_BREATH_GAMMA_EN
  localparam logic [2*DW-1:0] PWM_MAX_W = (2*DW)'(PWM_MAX);
  logic [2*DW-1:0] duty_sq;
  logic [2*DW-1:0] duty_gamma;
  assign duty_sq    = duty * duty;
  assign duty_gamma = duty_sq / PWM_MAX_W;
  assign cmp        = duty_gamma[DW-1:0];
`else
  assign cmp = duty;
`endif

  led_pwm_gen #(
    .PWM_MAX (PWM_MAX),
    .DW      (DW)
  ) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .en         (active),
    .clr        (start_acc || stop_acc),
    .cmp        (cmp),
    .period_end (period_end),
    .pwm_out    (pwm_out)
  );

  // Route the single registered PWM bit onto the active channel.
  always_comb begin
    led = '0;
    if (pwm_out) led[cur_ch] = 1'b1;
  end

  // Step divider: counts PWM periods so a duty step happens every STEP_DIV periods.
  always_ff @(posedge clk) begin
    if (rst || start_acc || stop_acc || !active) begin
      div_cnt <= '0;
    end else if (period_end) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
    end
  end

  // Main sequencer: phase transitions, duty ramp, hold timing and channel stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      duty     <= '0;
      hold_cnt <= '0;
      cur_ch   <= '0;
      loop_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop_acc) begin
        state    <= ST_IDLE;
        duty     <= '0;
        hold_cnt <= '0;
        cur_ch   <= '0;
        loop_q   <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_acc) begin
              state    <= ST_RAMP_UP;
              duty     <= '0;
              hold_cnt <= '0;
              cur_ch   <= '0;
              loop_q   <= loop;
              busy     <= 1'b1;
            end
          end

          ST_RAMP_UP: begin
            if (tick) begin
              duty <= duty + DUTY_ONE;
              if (duty == DUTY_PEN) begin
                state    <= ST_HOLD_ON;
                hold_cnt <= '0;
              end
            end
          end

          ST_HOLD_ON: begin
            if (tick) begin
              if (hold_cnt == HOLD_LAST) begin
                state    <= ST_RAMP_DOWN;
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + HOLD_ONE;
              end
            end
          end

          ST_RAMP_DOWN: begin
            if (tick) begin
              duty <= duty - DUTY_ONE;
              if (duty == DUTY_ONE) begin
                state    <= ST_HOLD_OFF;
                hold_cnt <= '0;
              end
            end
          end

          ST_HOLD_OFF: begin
            if (tick) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                if ((cur_ch == CH_LAST) && !loop_q) begin
                  // Last channel of a single pass: finish and park on channel 0.
                  state  <= ST_IDLE;
                  cur_ch <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                end else begin
                  state  <= ST_RAMP_UP;
                  cur_ch <= (cur_ch == CH_LAST) ? '0 : cur_ch + CH_ONE;
                end
              end else begin
                hold_cnt <= hold_cnt + HOLD_ONE;
              end
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_breath_seq.sv
// tb_led_breath_seq: self-checking bench for led_breath_seq with a small
// configuration (PWM_MAX=4, STEP_DIV=1, HOLD_TICKS=1, N_LED=2).
module tb_led_breath_seq;

  localparam int PM  = 4;
  localparam int SD  = 1;
  localparam int HT  = 1;
  localparam int NL  = 2;
  localparam int CL  = (2*PM + 2*HT) * SD * PM;   // clocks per channel
  localparam int RUN = NL * CL;                   // clocks per single pass

  logic          clk = 1'b0;
  logic          rst, start, stop, loop;
  logic [NL-1:0] led;
  logic [0:0]    cur_ch;
  logic          busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_breath_seq #(
    .PWM_MAX    (PM),
    .STEP_DIV   (SD),
    .HOLD_TICKS (HT),
    .N_LED      (NL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .loop   (loop),
    .led    (led),
    .cur_ch (cur_ch),
    .busy   (busy),
    .done   (done)
  );

  // ---------------- reference model ----------------
  function automatic int gam(input int d);
`ifdef LED_BREATH_GAMMA_EN
    return (d * d) / PM;
`else
    return d;
`endif
  endfunction

  // Duty in force during PWM period p of a channel (p counted from channel start).
  function automatic int duty_of_period(input int p);
    int s;
    s = p / SD;
    if (s < PM)          return s;
    if (s < PM + HT)     return PM;
    if (s < 2*PM + HT)   return PM - (s - (PM + HT));
    return 0;
  endfunction

  // Channel expected j cycles after the start-accepting edge.
  function automatic int exp_ch(input int j);
    return (j / CL) % NL;
  endfunction

  // LED vector expected j cycles after the start-accepting edge (one-cycle compare latency).
  function automatic logic [NL-1:0] exp_led(input int j);
    int e, pos;
    logic [NL-1:0] v;
    v = '0;
    if (j == 0) return v;
    e   = j - 1;
    pos = e % CL;
    if ((pos % PM) < gam(duty_of_period(pos / PM))) v[(e / CL) % NL] = 1'b1;
    return v;
  endfunction

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    repeat (3) tick_clk();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (led !== '0) begin errors++; $display("FAIL reset_led got %b exp 00", led); end
    checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL reset_ch got %b exp 0", cur_ch); end
    tick_clk();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_stays_idle got %b exp 0", busy); end
  endtask

  task automatic test_single_run();
    int busy_cnt, done_cnt;
    int per [0:9];
`ifdef LED_BREATH_GAMMA_EN
    int shape [0:9] = '{0, 0, 1, 2, 4, 4, 2, 1, 0, 0};
`else
    int shape [0:9] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
`endif
    busy_cnt = 0; done_cnt = 0;
    for (int p = 0; p < 10; p++) per[p] = 0;
    loop = 1'b0; start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int j = 0; j <= RUN + 1; j++) begin
      if (j > 0) tick_clk();
      checks++;
      if (busy !== (j < RUN)) begin errors++; $display("FAIL run_busy j=%0d got %b exp %b", j, busy, (j < RUN)); end
      checks++;
      if (done !== (j == RUN)) begin errors++; $display("FAIL run_done j=%0d got %b exp %b", j, done, (j == RUN)); end
      checks++;
      if (led !== ((j <= RUN) ? exp_led(j) : '0)) begin
        errors++; $display("FAIL run_led j=%0d got %b exp %b", j, led, (j <= RUN) ? exp_led(j) : '0);
      end
      if (j < RUN) begin
        checks++;
        if (cur_ch !== 1'(exp_ch(j))) begin errors++; $display("FAIL run_ch j=%0d got %0d exp %0d", j, cur_ch, exp_ch(j)); end
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (j >= 1 && j <= CL) per[(j - 1) / PM] += int'(led[0]);
      // Stray start mid-run and a wiggling loop input must both be ignored.
      start = (j == 9);
      loop  = (j < RUN - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0; loop = 1'b0;
    checks++; if (busy_cnt !== RUN) begin errors++; $display("FAIL run_busy_len got %0d exp %0d", busy_cnt, RUN); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL run_done_count got %0d exp 1", done_cnt); end
    for (int p = 0; p < 10; p++) begin
      checks++;
      if (per[p] !== shape[p]) begin errors++; $display("FAIL run_shape period=%0d got %0d exp %0d", p, per[p], shape[p]); end
    end
  endtask

  task automatic test_loop(input int stop_at);
    loop = 1'b1; start = 1'b1;
    tick_clk();
    start = 1'b0;
    for (int j = 0; j <= stop_at + 3; j++) begin
      if (j > 0) tick_clk();
      checks++;
      if (busy !== (j < stop_at)) begin errors++; $display("FAIL loop_busy j=%0d got %b exp %b", j, busy, (j < stop_at)); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL loop_done j=%0d got %b exp 0", j, done); end
      checks++;
      if (led !== ((j < stop_at) ? exp_led(j) : '0)) begin
        errors++; $display("FAIL loop_led j=%0d got %b exp %b", j, led, (j < stop_at) ? exp_led(j) : '0);
      end
      checks++;
      if (cur_ch !== ((j < stop_at) ? 1'(exp_ch(j)) : 1'b0)) begin
        errors++; $display("FAIL loop_ch j=%0d got %0d exp %0d", j, cur_ch, (j < stop_at) ? exp_ch(j) : 0);
      end
      stop = (j == stop_at - 1);
      loop = (j < stop_at - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    stop = 1'b0; loop = 1'b0;
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    tick_clk();
    start = 1'b0; stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy !== 1'b0 || led !== '0 || done !== 1'b0) begin
        errors++; $display("FAIL start_stop_idle k=%0d got busy=%b led=%b done=%b exp 0/00/0", k, busy, led, done);
      end
      tick_clk();
    end
  endtask

  task automatic test_stop_single();
    int k;
    k = $urandom_range(1, RUN - 1);
    loop = 1'b0; start = 1'b1;
    tick_clk();
    start = 1'b0;
    repeat (k - 1) tick_clk();
    stop = 1'b1;
    tick_clk();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy k=%0d got %b exp 0", k, busy); end
    checks++; if (led !== '0) begin errors++; $display("FAIL stop_led k=%0d got %b exp 00", k, led); end
    checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL stop_ch k=%0d got %b exp 0", k, cur_ch); end
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL stop_quiet m=%0d got done=%b busy=%b exp 0/0", m, done, busy);
      end
      tick_clk();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    loop = 1'b0; start = 1'b1;
    tick_clk();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < RUN + 10) begin tick_clk(); n++; end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done timeout got %b exp 1", done); end
    checks++; if (n !== RUN) begin errors++; $display("FAIL b2b_first_len got %0d exp %0d", n, RUN); end
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b exp 1", busy); end
    checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL b2b_restart_ch got %b exp 0", cur_ch); end
    n = 0;
    while (busy === 1'b1 && n < RUN + 10) begin n++; tick_clk(); end
    checks++; if (n !== RUN) begin errors++; $display("FAIL b2b_second_len got %0d exp %0d", n, RUN); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got %b exp 1", done); end
    tick_clk();
  endtask

  task automatic test_reset_mid();
    int k;
    k = $urandom_range(20, 60);
    loop = 1'b1; start = 1'b1;
    tick_clk();
    start = 1'b0; loop = 1'b0;
    repeat (k) tick_clk();
    rst = 1'b1;
    repeat (3) tick_clk();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy k=%0d got %b exp 0", k, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done k=%0d got %b exp 0", k, done); end
    checks++; if (led !== '0) begin errors++; $display("FAIL midrst_led k=%0d got %b exp 00", k, led); end
    checks++; if (cur_ch !== 1'b0) begin errors++; $display("FAIL midrst_ch k=%0d got %b exp 0", k, cur_ch); end
    tick_clk();
    checks++; if (busy !== 1'b0 || led !== '0) begin errors++; $display("FAIL midrst_idle got busy=%b led=%b exp 0/00", busy, led); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    test_reset();
    test_single_run();
    test_loop(100);
    test_loop($urandom_range(RUN + 1, 2 * RUN + 20));
    test_start_stop_idle();
    test_stop_single();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
